// File: rtl/img_sram_pkg.sv
// Shared types and constants for the image SRAM arbiter slice.
// Latency: none (types and a pure helper function only).
// Backpressure: not applicable.
package img_sram_pkg;

  localparam int IMG_DIM = 256;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 8;
  localparam int LEN_W   = 9;

  typedef logic [PIX_W-1:0]    pix_t;
  typedef logic [ADDR_W-1:0]   coord_t;
  typedef logic [LEN_W-1:0]    len_t;
  typedef logic [2*ADDR_W-1:0] addr_flat_t;

  typedef struct packed {
    coord_t row;
    coord_t col;
  } img_addr_t;

  typedef enum logic [1:0] {IDLE, BURST, LAST} arb_state_e;
  typedef enum logic [1:0] {HOLD, READ, WRITE} sram_op_e;

  // Raster step. Row sits above col in the packed struct, so a plain
  // increment carries col 255 into the next row and (255,255) wraps to (0,0).
  function automatic img_addr_t raster_next(input img_addr_t a);
    return img_addr_t'(addr_flat_t'(a) + addr_flat_t'(1));
  endfunction

endpackage

// File: rtl/img_sram_arbiter_if.sv
// Bundle of loader write, burst command, read data and SRAM pin signals.
// Latency: none (wires only).
// Backpressure: wr_ready / rd_cmd_ready; rd_data has no backpressure.
interface img_sram_arbiter_if;
  import img_sram_pkg::*;

  logic   wr_valid;
  logic   wr_ready;
  coord_t wr_row;
  coord_t wr_col;
  pix_t   wr_data;

  logic   rd_cmd_valid;
  logic   rd_cmd_ready;
  coord_t rd_cmd_row;
  coord_t rd_cmd_col;
  len_t   rd_cmd_len;

  logic   rd_data_valid;
  pix_t   rd_data;
  logic   rd_data_last;
  logic   rd_busy;

  coord_t sram_row;
  coord_t sram_col;
  pix_t   sram_din;
  logic   sram_write_en;
  logic   sram_sense_en;
  pix_t   sram_dout;

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_data,
    input  rd_cmd_valid, rd_cmd_row, rd_cmd_col, rd_cmd_len,
    input  sram_dout,
    output wr_ready, rd_cmd_ready,
    output rd_data_valid, rd_data, rd_data_last, rd_busy,
    output sram_row, sram_col, sram_din, sram_write_en, sram_sense_en
  );

  modport master (
    output wr_valid, wr_row, wr_col, wr_data,
    output rd_cmd_valid, rd_cmd_row, rd_cmd_col, rd_cmd_len,
    output sram_dout,
    input  wr_ready, rd_cmd_ready,
    input  rd_data_valid, rd_data, rd_data_last, rd_busy,
    input  sram_row, sram_col, sram_din, sram_write_en, sram_sense_en
  );

endinterface

// File: rtl/img_sram_addr_gen.sv
// Raster address counter for read bursts: load start/length, step per issued beat.
// Latency: addr/last_beat update one clock after load or step.
// Backpressure: none; the caller steps only when a beat is actually issued.
module img_sram_addr_gen
  import img_sram_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  img_addr_t load_addr,
  input  len_t      load_len,
  input  logic      step,
  output img_addr_t addr,
  output logic      last_beat
);

  len_t remaining;

  // Current beat address and beats still to issue; load has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr      <= raster_next(addr);
      remaining <= remaining - len_t'(1);
    end
  end

  assign last_beat = (remaining == len_t'(1));

endmodule

// File: rtl/img_sram_arbiter.sv
// Shares one SRAM port between single-beat loader writes and raster read bursts (optional IMG_SRAM_ARB_PERF_EN perf counters).
// Latency: write/read reaches SRAM pins 1 clk after grant; burst data 2 clks after cmd accept uncontended.
// Backpressure: wr_ready is the per-cycle grant; rd_cmd_ready only when idle; rd_data cannot be stalled.
module img_sram_arbiter
  import img_sram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  img_sram_arbiter_if.slave  bus
`ifdef IMG_SRAM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_wr_cnt,
  output logic [31:0]        perf_rd_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  arb_state_e state, state_nxt;
  sram_op_e   op_nxt;
  logic       rr_wr_pri;      // 1: write wins the next contended cycle
  logic       wr_pend, rd_pend, contended;
  logic       grant_wr, grant_rd;
  logic       gen_load;
  img_addr_t  gen_addr;
  logic       gen_last;

  coord_t     sram_row_q, sram_col_q;
  pix_t       sram_din_q;
  logic       sram_we_q, sram_se_q;
  logic       rd_inflight;    // a read was issued at the last posedge
  logic       last_inflight;  // ...and it was the final beat of its burst

  img_sram_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (gen_load),
    .load_addr ('{row: bus.rd_cmd_row, col: bus.rd_cmd_col}),
    .load_len  (bus.rd_cmd_len),
    .step      (grant_rd),
    .addr      (gen_addr),
    .last_beat (gen_last)
  );

  assign rd_inflight = !sram_se_q;

  // Arbitration, SRAM op selection and FSM next state.
  always_comb begin
    state_nxt = state;
    op_nxt    = HOLD;
    wr_pend   = bus.wr_valid && !rst;
    rd_pend   = (state == BURST);
    contended = wr_pend && rd_pend;
    grant_wr  = wr_pend && (!rd_pend || rr_wr_pri);
    grant_rd  = rd_pend && (!wr_pend || !rr_wr_pri);
    gen_load  = (state == IDLE) && bus.rd_cmd_valid && (bus.rd_cmd_len != '0);

    if (grant_wr)      op_nxt = WRITE;
    else if (grant_rd) op_nxt = READ;

    case (state)
      IDLE:    if (gen_load)             state_nxt = BURST;
      BURST:   if (grant_rd && gen_last) state_nxt = LAST;
      LAST:    if (rd_inflight)          state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // FSM state and round-robin pointer (flips only on contended grants).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_wr_pri <= 1'b1;
    end else begin
      state <= state_nxt;
      if (contended) rr_wr_pri <= !rr_wr_pri;
    end
  end

  // SRAM pin registers; address/data hold when the port idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_row_q    <= '0;
      sram_col_q    <= '0;
      sram_din_q    <= '0;
      sram_we_q     <= 1'b0;
      sram_se_q     <= 1'b1;
      last_inflight <= 1'b0;
    end else begin
      sram_we_q     <= (op_nxt == WRITE);
      sram_se_q     <= (op_nxt != READ);
      last_inflight <= grant_rd && gen_last;
      case (op_nxt)
        WRITE: begin
          sram_row_q <= bus.wr_row;
          sram_col_q <= bus.wr_col;
          sram_din_q <= bus.wr_data;
        end
        READ: begin
          sram_row_q <= gen_addr.row;
          sram_col_q <= gen_addr.col;
        end
        default: ;
      endcase
    end
  end

  // Capture read data at the posedge following each read issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data_valid <= 1'b0;
      bus.rd_data       <= '0;
      bus.rd_data_last  <= 1'b0;
    end else begin
      bus.rd_data_valid <= rd_inflight;
      bus.rd_data_last  <= rd_inflight && last_inflight;
      if (rd_inflight) bus.rd_data <= bus.sram_dout;
    end
  end

  assign bus.wr_ready      = grant_wr;
  assign bus.rd_cmd_ready  = (state == IDLE);
  assign bus.rd_busy       = (state != IDLE);
  assign bus.sram_row      = sram_row_q;
  assign bus.sram_col      = sram_col_q;
  assign bus.sram_din      = sram_din_q;
  assign bus.sram_write_en = sram_we_q;
  assign bus.sram_sense_en = sram_se_q;

`ifdef IMG_SRAM_ARB_PERF_EN
  // Saturating counters: granted writes, issued read beats, lost-arbitration cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_wr_cnt    <= '0;
      perf_rd_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (grant_wr && perf_wr_cnt != '1)     perf_wr_cnt    <= perf_wr_cnt + 32'd1;
      if (grant_rd && perf_rd_cnt != '1)     perf_rd_cnt    <= perf_rd_cnt + 32'd1;
      if (contended && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_img_sram_arbiter.sv
// Bench for img_sram_arbiter: SRAM array model plus reference image memory and raster expectations.
// Latency: checks first-data timing and per-beat issue/data ordering.
// Backpressure: drives loader writes held until granted and commands held until accepted.
module tb_img_sram_arbiter;
  import img_sram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  img_sram_arbiter_if bus();

`ifdef IMG_SRAM_ARB_PERF_EN
  logic [31:0] perf_wr_cnt, perf_rd_cnt, perf_stall_cnt;
  img_sram_arbiter dut (.clk(clk), .rst(rst), .bus(bus),
                        .perf_wr_cnt(perf_wr_cnt), .perf_rd_cnt(perf_rd_cnt),
                        .perf_stall_cnt(perf_stall_cnt));
`else
  img_sram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct packed {
    img_addr_t a;
    logic      last;
  } beat_t;

  pix_t  mem     [IMG_DIM][IMG_DIM];  // the SRAM array itself
  pix_t  ref_mem [IMG_DIM][IMG_DIM];  // what the image should contain
  beat_t iss_q[$];
  beat_t dat_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_seen = 0;
  int    data_seen = 0;
  int    wr_mode = 0;                 // 0 off, 1 random rows 128..131, 2 always valid rows 200..255

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: samples pins mid-cycle, read data presented for the next posedge.
  always @(negedge clk) begin
    if (bus.sram_write_en) mem[bus.sram_row][bus.sram_col] = bus.sram_din;
    if (!bus.sram_sense_en) bus.sram_dout = mem[bus.sram_row][bus.sram_col];
    else                    bus.sram_dout = pix_t'($urandom);
  end

  // Monitor: track writes into the reference image, check issued read addresses and returned data.
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      if (bus.wr_valid && bus.wr_ready) ref_mem[bus.wr_row][bus.wr_col] = bus.wr_data;
      if (!bus.sram_sense_en) begin
        if (iss_q.size() == 0) chk("rd_issue_unexpected", 1, 0);
        else begin
          b = iss_q.pop_front();
          chk("rd_row", bus.sram_row, b.a.row);
          chk("rd_col", bus.sram_col, b.a.col);
        end
      end
      if (bus.rd_data_valid) begin
        data_seen++;
        if (dat_q.size() == 0) chk("rd_data_unexpected", 1, 0);
        else begin
          b = dat_q.pop_front();
          chk("rd_data", bus.rd_data, ref_mem[b.a.row][b.a.col]);
          chk("rd_last", bus.rd_data_last, b.last);
        end
        if (bus.rd_data_last) last_seen++;
      end else if (bus.rd_data_last) chk("last_without_valid", 1, 0);
    end
  end

  task automatic send_cmd(input int row, input int col, input int len, output int acc_edge);
    beat_t b;
    int    lin;
    bit    ok = 0;
    acc_edge = -1;
    bus.rd_cmd_valid = 1'b1;
    bus.rd_cmd_row   = coord_t'(row);
    bus.rd_cmd_col   = coord_t'(col);
    bus.rd_cmd_len   = len_t'(len);
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (bus.rd_cmd_ready) begin
        ok = 1;
        acc_edge = cyc + 1;
        for (int i = 0; i < len; i++) begin
          lin      = (row * IMG_DIM + col + i) % (IMG_DIM * IMG_DIM);
          b.a.row  = coord_t'(lin / IMG_DIM);
          b.a.col  = coord_t'(lin % IMG_DIM);
          b.last   = (i == len - 1);
          iss_q.push_back(b);
          dat_q.push_back(b);
        end
      end
      @(posedge clk); #1;
    end
    bus.rd_cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (dat_q.size() == 0 && iss_q.size() == 0 && !bus.rd_busy) ok = 1;
    end
    chk("burst_done", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int row, input int col, input int data);
    bit ok = 0;
    bus.wr_valid = 1'b1;
    bus.wr_row   = coord_t'(row);
    bus.wr_col   = coord_t'(col);
    bus.wr_data  = pix_t'(data);
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.wr_ready) ok = 1;
      @(posedge clk); #1;
    end
    bus.wr_valid = 1'b0;
    if (!ok) chk("wr_grant_timeout", 0, 1);
  endtask

  task automatic wr_background();
    bit hs;
    forever begin
      @(negedge clk);
      hs = bus.wr_valid && bus.wr_ready;
      @(posedge clk); #1;
      if (wr_mode != 0 && (hs || !bus.wr_valid)) begin
        bus.wr_valid = (wr_mode == 2) || ($urandom_range(0, 1) == 1);
        bus.wr_row   = (wr_mode == 2) ? coord_t'($urandom_range(200, 255))
                                      : coord_t'($urandom_range(128, 131));
        bus.wr_col   = coord_t'($urandom);
        bus.wr_data  = pix_t'($urandom);
      end
    end
  endtask

  task automatic wr_quiesce();
    bit ok = 0;
    wr_mode = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (!bus.wr_valid || bus.wr_ready) ok = 1;
      @(posedge clk); #1;
    end
    bus.wr_valid = 1'b0;
    chk("wr_quiesce", ok, 1);
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_wr_ready"},      bus.wr_ready, 0);
    chk({pfx, "_rd_cmd_ready"},  bus.rd_cmd_ready, 1);
    chk({pfx, "_rd_data_valid"}, bus.rd_data_valid, 0);
    chk({pfx, "_rd_data"},       bus.rd_data, 0);
    chk({pfx, "_rd_data_last"},  bus.rd_data_last, 0);
    chk({pfx, "_rd_busy"},       bus.rd_busy, 0);
    chk({pfx, "_sram_row"},      bus.sram_row, 0);
    chk({pfx, "_sram_col"},      bus.sram_col, 0);
    chk({pfx, "_sram_din"},      bus.sram_din, 0);
    chk({pfx, "_sram_we"},       bus.sram_write_en, 0);
    chk({pfx, "_sram_se"},       bus.sram_sense_en, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog cycles=%0d limit=60000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, seen, base_last, base_data, op, len;

    for (int r = 0; r < IMG_DIM; r++)
      for (int c = 0; c < IMG_DIM; c++) begin
        mem[r][c]     = pix_t'(r * 31 + c * 7 + 5);
        ref_mem[r][c] = pix_t'(r * 31 + c * 7 + 5);
      end
    bus.wr_valid = 0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
    bus.rd_cmd_valid = 0; bus.rd_cmd_row = '0; bus.rd_cmd_col = '0; bus.rd_cmd_len = '0;
    fork
      wr_background();
    join_none

    // 1: reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // 2: write then single-beat burst, latency two edges after accept
    do_write(3, 7, 8'hA5);
    send_cmd(3, 7, 1, acc);
    seen = -1;
    for (int n = 0; n < 20 && seen < 0; n++) begin
      @(negedge clk);
      if (bus.rd_data_valid) begin
        seen = cyc;
        chk("t2_data", bus.rd_data, 8'hA5);
        chk("t2_last", bus.rd_data_last, 1);
      end
    end
    chk("t2_latency", seen - acc, 2);
    wait_idle();

    // 3: raster wrap across a row and across the image corner
    send_cmd(10, 254, 4, acc);
    wait_idle();
    send_cmd(255, 255, 2, acc);
    wait_idle();

    // 4: write held valid during an 8-beat burst -> alternating grants
    wr_mode = 2;
    repeat (4) @(posedge clk);
    #1;
    base_last = last_seen;
    send_cmd(20, 5, 8, acc);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      op = bus.sram_write_en ? 2 : (!bus.sram_sense_en ? 1 : 0);
      chk($sformatf("t4_op%0d", i), op, (i == 0 || i % 2 == 1) ? 2 : 1);
    end
    wait_idle();
    chk("t4_last_count", last_seen - base_last, 1);
    wr_quiesce();

    // 5: zero-length and full-row-length bursts
    send_cmd(5, 5, 0, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_len0_busy", bus.rd_busy, 0);
      chk("t5_len0_valid", bus.rd_data_valid, 0);
      chk("t5_len0_se", bus.sram_sense_en, 1);
    end
    @(posedge clk); #1;
    base_last = last_seen;
    base_data = data_seen;
    send_cmd(50, 17, 256, acc);
    wait_idle();
    chk("t5_len256_beats", data_seen - base_data, 256);
    chk("t5_len256_last", last_seen - base_last, 1);

    // 6: reset in the middle of a burst, then a fresh burst
    send_cmd(60, 100, 50, acc);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    iss_q.delete();
    dat_q.delete();
    @(posedge clk); #1;
    check_reset("midrst");
    rst = 1'b0;
    @(posedge clk); #1;
    send_cmd(60, 100, 5, acc);
    wait_idle();

    // random bursts against random background writes in a disjoint region
    wr_mode = 1;
    for (int k = 0; k < 20; k++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 256);
      send_cmd($urandom_range(0, 99), $urandom_range(0, 255), len, acc);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wr_quiesce();
    repeat (3) @(posedge clk);
    #1;

    // read back the randomly written rows
    for (int r = 128; r < 132; r++) begin
      send_cmd(r, 0, 256, acc);
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
